cla_mult_seq: RTL and testbench

- Iterative 16x16 unsigned shift-add multiplier sequencer built around one shared 16-bit CLA (sub tied 0).
- One partial-product add per cycle; 32-bit product after 16 iterations.
- Sits beside the ALU as the MUL execution unit; the pipeline stalls on busy.

---
 rtl/cla_mult_seq.sv | 107 ++++++++++
 tb/tb_cla_mult_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/cla_mult_seq.sv
// Iterative 16x16 unsigned shift-add multiplier: one CLA add per cycle over 16
// iterations, producing a registered 32-bit product with a does-not-fit-16-bits flag.
module cla_mult_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Product,
  output logic        Ovfl
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] mcand, hi, lo;
  logic [3:0]  cnt;
  logic [15:0] cla_x, cla_y, cla_s;
  logic        carry;
  logic [15:0] hi_next, lo_next;
  logic        load, last;

  // 16-bit carry-lookahead adder: 4-bit groups with group generate/propagate.
  function automatic logic [15:0] cla_sum(input logic [15:0] x, input logic [15:0] y,
                                          input logic cin);
    logic [15:0] g, p, c;
    logic [2:0]  gg, gp;
    logic [3:0]  gc;
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < 3; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+3 -: 2] & g[4*k+1])
            | (&p[4*k+3 -: 3] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (&gp & cin);
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) c[i] = gc[i/4];
      else            c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    return p ^ c;
  endfunction

  always_comb begin
    cla_x   = hi;
    cla_y   = lo[0] ? mcand : 16'h0000;
    cla_s   = cla_sum(cla_x, cla_y, 1'b0);
    // Carry-out recovered from the operand and sum MSBs rather than the adder.
    carry   = (cla_x[15] & cla_y[15]) | ((cla_x[15] ^ cla_y[15]) & ~cla_s[15]);
    hi_next = {carry, cla_s[15:1]};
    lo_next = {cla_s[0], lo[15:1]};
    load    = start && ((state == IDLE) || (state == DONE));
    last    = (state == RUN) && (cnt == 4'd15);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == 4'd15) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= 16'h0000;
      hi      <= 16'h0000;
      lo      <= 16'h0000;
      cnt     <= 4'd0;
      Product <= 32'h0000_0000;
      Ovfl    <= 1'b0;
    end else if (load) begin
      mcand <= A;
      hi    <= 16'h0000;
      lo    <= B;
      cnt   <= 4'd0;
    end else if (state == RUN) begin
      hi  <= hi_next;
      lo  <= lo_next;
      cnt <= cnt + 4'd1;
      if (last) begin
        Product <= {hi_next, lo_next};
        Ovfl    <= |hi_next;
      end
    end
  end

endmodule

// File: tb/tb_cla_mult_seq.sv
// Directed bench for cla_mult_seq: latency, products, overflow flag, ignored
// starts, back-to-back acceptance and mid-operation reset.
module tb_cla_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A, B;
  logic        busy, done;
  logic [31:0] Product;
  logic        Ovfl;

  int checks   = 0;
  int failures = 0;

  cla_mult_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Product(Product), .Ovfl(Ovfl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives a start at the current negedge and returns at the negedge where done is seen.
  task automatic mul(input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] ep, input logic eo, input string tag);
    int lat, bcnt;
    A = a; B = b; start = 1'b1;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bcnt++;
    end while (!done && lat < 40);
    check({tag, "_latency"}, 64'(lat), 64'd17);
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'd16);
    check({tag, "_product"}, 64'(Product), 64'(ep));
    check({tag, "_ovfl"}, 64'(Ovfl), 64'(eo));
    check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat, seen;
    rst = 1'b1; start = 1'b0; A = 16'h0; B = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("idle_product", 64'(Product), 64'd0);
      check("idle_ovfl", 64'(Ovfl), 64'd0);
    end

    mul(16'd3, 16'd5, 32'h0000_000F, 1'b0, "m3x5");
    @(negedge clk);
    check("m3x5_done_pulse", 64'(done), 64'd0);
    check("m3x5_held", 64'(Product), 64'h0000_000F);

    mul(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1, "mffff");
    @(negedge clk);

    // Second op is requested during the DONE cycle of the first.
    mul(16'h0100, 16'h0100, 32'h0001_0000, 1'b1, "m0100");
    mul(16'h1234, 16'h0000, 32'h0000_0000, 1'b0, "b2b");
    @(negedge clk);
    check("b2b_done_pulse", 64'(done), 64'd0);
    check("b2b_idle_busy", 64'(busy), 64'd0);

    // 7*9 with a stray start three cycles into RUN.
    A = 16'd7; B = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    A = 16'd2; B = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 5;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("m7x9_latency", 64'(lat), 64'd17);
    check("m7x9_product", 64'(Product), 64'h0000_003F);
    check("m7x9_ovfl", 64'(Ovfl), 64'd0);
    @(negedge clk);
    check("m7x9_no_queue", 64'(busy), 64'd0);

    // Reset after iteration 8 of 0xABCD*0x1111.
    A = 16'hABCD; B = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(Product), 64'd0);
    check("rst_ovfl", 64'(Ovfl), 64'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("rst_no_done", 64'(seen), 64'd0);

    mul(16'hABCD, 16'h1111, 32'h0B74_059D, 1'b1, "mabcd");
    @(negedge clk);
    check("mabcd_held", 64'(Product), 64'h0B74_059D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
